// File: rtl/m_ctrl_pkg.sv
// m_ctrl_pkg: shared encodings for the multi-cycle MIPS control unit.
// Holds state codes, opcode/funct values, ALU_operation codes, datapath
// mux-select encodings and the packed bundle of datapath control outputs.
package m_ctrl_pkg;
    typedef enum logic [4:0] {
        S_IF, S_ID, S_MA, S_MRD, S_MWR, S_WBL, S_EXR, S_WBR,
        S_EXI, S_WBI, S_BR, S_J, S_JAL, S_JR, S_LUI, S_HALT
    } state_t;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011, OP_LUI = 6'b001111;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI = 6'b001101, OP_XORI = 6'b001110;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_XOR = 6'b100110, F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010, F_SRL = 6'b000010, F_JR = 6'b001000;
    localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010, ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100, ALU_SRL = 3'b101, ALU_SUB = 3'b110, ALU_SLT = 3'b111;
    localparam logic [1:0] MTR_ALU = 2'b00, MTR_MDR = 2'b01, MTR_LUI = 2'b10, MTR_PC = 2'b11;
    localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_31 = 2'b10;
    localparam logic [1:0] SB_B = 2'b00, SB_4 = 2'b01, SB_IMM = 2'b10, SB_IMM2 = 2'b11;
    localparam logic [1:0] PS_ALU = 2'b00, PS_ALUOUT = 2'b01, PS_JUMP = 2'b10, PS_A = 2'b11;
    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic       IorD;
        logic       IRWrite;
        logic       ALUSrcA;
        logic       RegWrite;
        logic       Branch;
        logic [1:0] MemtoReg;
        logic [1:0] RegDst;
        logic [1:0] ALUSrcB;
        logic [1:0] PCSource;
        logic [2:0] ALU_operation;
        logic       MemRead;
        logic       MemWrite;
        logic       CPU_MIO;
    } ctrl_t;
endpackage

// File: rtl/m_ctrl_fsm_if.sv
// m_ctrl_fsm_if: control-unit <-> datapath/bus signal bundle.
// master (control unit): in Inst, zero, overflow, MIO_ready; out ctl, state,
// mem_timeout, illegal. slave (datapath side): the mirror image.
interface m_ctrl_fsm_if;
    import m_ctrl_pkg::*;
    logic [31:0] Inst;
    logic        zero;
    logic        overflow;
    logic        MIO_ready;
    ctrl_t       ctl;
    logic [4:0]  state;
    logic        mem_timeout;
    logic        illegal;
    modport master (input Inst, zero, overflow, MIO_ready, output ctl, state, mem_timeout, illegal);
    modport slave (output Inst, zero, overflow, MIO_ready, input ctl, state, mem_timeout, illegal);
endinterface

// File: rtl/m_alu_dec.sv
// m_alu_dec: opcode/funct -> ALU_operation decoder for R-type and I-type ALU ops.
// Ports: op_i, funct_i in; alu_op_o ALU code, alu_ok_o instruction is a known
// ALU op, ovf_en_o overflow is meaningful (add, sub, addi).
module m_alu_dec
    import m_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_op_o,
    output logic       alu_ok_o,
    output logic       ovf_en_o
);
    always_comb begin
        alu_op_o = ALU_ADD;
        alu_ok_o = 1'b1;
        ovf_en_o = 1'b0;
        if (op_i == OP_R) begin
            case (funct_i)
                F_ADD: begin alu_op_o = ALU_ADD; ovf_en_o = 1'b1; end
                F_SUB: begin alu_op_o = ALU_SUB; ovf_en_o = 1'b1; end
                F_AND: alu_op_o = ALU_AND;
                F_OR:  alu_op_o = ALU_OR;
                F_XOR: alu_op_o = ALU_XOR;
                F_NOR: alu_op_o = ALU_NOR;
                F_SLT: alu_op_o = ALU_SLT;
                F_SRL: alu_op_o = ALU_SRL;
                default: alu_ok_o = 1'b0;
            endcase
        end else begin
            case (op_i)
                OP_ADDI: begin alu_op_o = ALU_ADD; ovf_en_o = 1'b1; end
                OP_SLTI: alu_op_o = ALU_SLT;
                OP_ANDI: alu_op_o = ALU_AND;
                OP_ORI:  alu_op_o = ALU_OR;
                OP_XORI: alu_op_o = ALU_XOR;
                default: alu_ok_o = 1'b0;
            endcase
        end
    end
endmodule

// File: rtl/m_ctrl_fsm.sv
// m_ctrl_fsm: multi-cycle MIPS control unit (Moore FSM) sequencing M_datapath.
// Ports: clk, reset (async, active-high), ctrl (m_ctrl_fsm_if.master).
// Parameter MEM_TIMEOUT: memory-wait watchdog in cycles, 0 disables it.
// Macro ILLEGAL_TRAP_EN: illegal instructions trap to HALT instead of acting as NOPs.
module m_ctrl_fsm
    import m_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0
) (
    input logic          clk,
    input logic          reset,
    m_ctrl_fsm_if.master ctrl
);
    state_t      state_q, state_d;
    logic        ovf_q, ovf_d, to_q, to_hit, wait_st;
    logic [15:0] cnt_q, cnt_d;
    logic [5:0]  op, funct;
    logic [2:0]  alu_op;
    logic        alu_ok, ovf_en, unused;
    ctrl_t       c;
`ifdef ILLEGAL_TRAP_EN
    localparam state_t S_BAD = S_HALT;
    assign ctrl.illegal = state_q == S_HALT;
`else
    localparam state_t S_BAD = S_IF;
    assign ctrl.illegal = 1'b0;
`endif
    assign op = ctrl.Inst[31:26];
    assign funct = ctrl.Inst[5:0];
    assign unused = ^{ctrl.zero, ctrl.Inst[25:6]};
    m_alu_dec u_dec (.op_i(op), .funct_i(funct), .alu_op_o(alu_op), .alu_ok_o(alu_ok), .ovf_en_o(ovf_en));
    // Counter only runs while stalled on memory; any state change or a timeout restarts it.
    assign wait_st = (state_q == S_IF || state_q == S_MRD || state_q == S_MWR) && !ctrl.MIO_ready;
    assign to_hit = (MEM_TIMEOUT > 0) && wait_st && (cnt_q == 16'(MEM_TIMEOUT - 1));
    assign cnt_d = (MEM_TIMEOUT > 0 && wait_st && !to_hit) ? cnt_q + 16'd1 : '0;
    assign ovf_d = (state_q == S_EXR || state_q == S_EXI) ? ctrl.overflow & ovf_en : ovf_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IF;
            ovf_q <= 1'b0;
            cnt_q <= '0;
            to_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
            to_q <= to_q | to_hit;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:  state_d = ctrl.MIO_ready ? S_ID : S_IF;
            S_ID: begin
                case (op)
                    OP_LW, OP_SW:   state_d = S_MA;
                    OP_R:           state_d = funct == F_JR ? S_JR : alu_ok ? S_EXR : S_BAD;
                    OP_BEQ, OP_BNE: state_d = S_BR;
                    OP_J:           state_d = S_J;
                    OP_JAL:         state_d = S_JAL;
                    OP_LUI:         state_d = S_LUI;
                    default:        state_d = alu_ok ? S_EXI : S_BAD;
                endcase
            end
            S_MA:   state_d = op == OP_LW ? S_MRD : S_MWR;
            S_MRD:  state_d = ctrl.MIO_ready ? S_WBL : to_hit ? S_IF : S_MRD;
            S_MWR:  state_d = (ctrl.MIO_ready || to_hit) ? S_IF : S_MWR;
            S_EXR:  state_d = S_WBR;
            S_EXI:  state_d = S_WBI;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end
    always_comb begin
        c = '0;
        case (state_q)
            S_IF: begin
                c.MemRead = 1'b1;
                c.CPU_MIO = 1'b1;
                c.ALUSrcB = SB_4;
                c.ALU_operation = ALU_ADD;
                c.IRWrite = ctrl.MIO_ready;
                c.PCWrite = ctrl.MIO_ready;
            end
            S_ID: begin
                c.ALUSrcB = SB_IMM2;
                c.ALU_operation = ALU_ADD;
            end
            S_MA: begin
                c.ALUSrcA = 1'b1;
                c.ALUSrcB = SB_IMM;
                c.ALU_operation = ALU_ADD;
            end
            S_MRD: begin
                c.IorD = 1'b1;
                c.MemRead = 1'b1;
                c.CPU_MIO = 1'b1;
            end
            S_MWR: begin
                c.IorD = 1'b1;
                c.MemWrite = 1'b1;
                c.CPU_MIO = 1'b1;
            end
            S_WBL: begin
                c.RegWrite = 1'b1;
                c.MemtoReg = MTR_MDR;
            end
            S_EXR: begin
                c.ALUSrcA = 1'b1;
                c.ALU_operation = alu_op;
            end
            S_WBR: begin
                c.RegWrite = !ovf_q;
                c.RegDst = RD_RD;
            end
            S_EXI: begin
                c.ALUSrcA = 1'b1;
                c.ALUSrcB = SB_IMM;
                c.ALU_operation = alu_op;
            end
            S_WBI: c.RegWrite = !ovf_q;
            S_BR: begin
                c.ALUSrcA = 1'b1;
                c.ALU_operation = ALU_SUB;
                c.PCSource = PS_ALUOUT;
                c.PCWriteCond = 1'b1;
                c.Branch = op == OP_BEQ;
            end
            S_J: begin
                c.PCWrite = 1'b1;
                c.PCSource = PS_JUMP;
            end
            S_JAL: begin
                c.PCWrite = 1'b1;
                c.PCSource = PS_JUMP;
                c.RegWrite = 1'b1;
                c.RegDst = RD_31;
                c.MemtoReg = MTR_PC;
            end
            S_JR: begin
                c.PCWrite = 1'b1;
                c.PCSource = PS_A;
            end
            S_LUI: begin
                c.RegWrite = 1'b1;
                c.MemtoReg = MTR_LUI;
            end
            default: c = '0;
        endcase
    end
    // Reset is asynchronous, so strobes must drop as soon as it rises, not at the next edge.
    assign ctrl.ctl = reset ? '0 : c;
    assign ctrl.state = state_q;
    assign ctrl.mem_timeout = to_q;
endmodule

// File: tb/tb_m_ctrl_fsm.sv
// tb_m_ctrl_fsm: scoreboard bench for m_ctrl_fsm (MEM_TIMEOUT=4).
module tb_m_ctrl_fsm;
    import m_ctrl_pkg::*;
    typedef struct {
        string  tag;
        state_t st;
        ctrl_t  v;
        logic   ill;
        logic   to;
    } exp_t;
    localparam ctrl_t C_IF_RDY = ctrl_t'{PCWrite: 1'b1, IRWrite: 1'b1, MemRead: 1'b1, CPU_MIO: 1'b1, ALUSrcB: 2'b01, ALU_operation: 3'b010, default: '0};
    localparam ctrl_t C_IF_WAIT = ctrl_t'{MemRead: 1'b1, CPU_MIO: 1'b1, ALUSrcB: 2'b01, ALU_operation: 3'b010, default: '0};
    localparam ctrl_t C_ID = ctrl_t'{ALUSrcB: 2'b11, ALU_operation: 3'b010, default: '0};
    localparam ctrl_t C_MA = ctrl_t'{ALUSrcA: 1'b1, ALUSrcB: 2'b10, ALU_operation: 3'b010, default: '0};
    localparam ctrl_t C_MRD = ctrl_t'{IorD: 1'b1, MemRead: 1'b1, CPU_MIO: 1'b1, default: '0};
    localparam ctrl_t C_MWR = ctrl_t'{IorD: 1'b1, MemWrite: 1'b1, CPU_MIO: 1'b1, default: '0};
    localparam ctrl_t C_WBL = ctrl_t'{RegWrite: 1'b1, MemtoReg: 2'b01, default: '0};
    localparam ctrl_t C_BEQ = ctrl_t'{PCWriteCond: 1'b1, Branch: 1'b1, ALUSrcA: 1'b1, PCSource: 2'b01, ALU_operation: 3'b110, default: '0};
    localparam ctrl_t C_BNE = ctrl_t'{PCWriteCond: 1'b1, ALUSrcA: 1'b1, PCSource: 2'b01, ALU_operation: 3'b110, default: '0};
    localparam ctrl_t C_J = ctrl_t'{PCWrite: 1'b1, PCSource: 2'b10, default: '0};
    localparam ctrl_t C_JAL = ctrl_t'{PCWrite: 1'b1, PCSource: 2'b10, RegWrite: 1'b1, RegDst: 2'b10, MemtoReg: 2'b11, default: '0};
    localparam ctrl_t C_JR = ctrl_t'{PCWrite: 1'b1, PCSource: 2'b11, default: '0};
    localparam ctrl_t C_LUI = ctrl_t'{RegWrite: 1'b1, MemtoReg: 2'b10, default: '0};
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mon_on = 1'b0;
    int total = 0;
    int bad = 0;
    exp_t q[$];
    m_ctrl_fsm_if bus ();
    m_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (.clk(clk), .reset(reset), .ctrl(bus));
    always #5 clk = ~clk;
    function automatic ctrl_t c_exr(input logic [2:0] a);
        c_exr = '0;
        c_exr.ALUSrcA = 1'b1;
        c_exr.ALU_operation = a;
    endfunction
    function automatic ctrl_t c_exi(input logic [2:0] a);
        c_exi = c_exr(a);
        c_exi.ALUSrcB = 2'b10;
    endfunction
    function automatic ctrl_t c_wb(input logic w, input logic [1:0] dst);
        c_wb = '0;
        c_wb.RegWrite = w;
        c_wb.RegDst = dst;
    endfunction
    task automatic cyc(input string tag, input state_t st, input ctrl_t v, input logic mio = 1'b1,
                       input logic ovf = 1'b0, input logic ill = 1'b0, input logic to = 1'b0);
        exp_t e;
        bus.MIO_ready = mio;
        bus.overflow = ovf;
        e.tag = tag;
        e.st = st;
        e.v = v;
        e.ill = ill;
        e.to = to;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask
    task automatic run_r(input string tag, input logic [31:0] inst, input logic [2:0] a, input logic ovf, input logic wr);
        bus.Inst = inst;
        cyc(tag, S_IF, C_IF_RDY);
        cyc(tag, S_ID, C_ID);
        cyc(tag, S_EXR, c_exr(a), 1'b1, ovf);
        cyc(tag, S_WBR, c_wb(wr, 2'b01));
    endtask
    task automatic run_i(input string tag, input logic [31:0] inst, input logic [2:0] a, input logic ovf, input logic wr);
        bus.Inst = inst;
        cyc(tag, S_IF, C_IF_RDY);
        cyc(tag, S_ID, C_ID);
        cyc(tag, S_EXI, c_exi(a), 1'b1, ovf);
        cyc(tag, S_WBI, c_wb(wr, 2'b00));
    endtask
    task automatic run3(input string tag, input logic [31:0] inst, input state_t st, input ctrl_t v);
        bus.Inst = inst;
        cyc(tag, S_IF, C_IF_RDY);
        cyc(tag, S_ID, C_ID);
        cyc(tag, st, v);
    endtask
    task automatic run_bad(input string tag, input logic [31:0] inst);
        bus.Inst = inst;
        cyc(tag, S_IF, C_IF_RDY);
        cyc(tag, S_ID, C_ID);
`ifdef ILLEGAL_TRAP_EN
        cyc(tag, S_HALT, '0, 1'b1, 1'b0, 1'b1);
        cyc(tag, S_HALT, '0, 1'b1, 1'b0, 1'b1);
`else
        cyc(tag, S_IF, C_IF_WAIT, 1'b0);
`endif
        reset = 1'b1;
        cyc("rst", S_IF, '0);
        reset = 1'b0;
    endtask
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL underflow: DUT cycle with no expectation, state=%0d", bus.state);
                end else begin
                    e = q.pop_front();
                    if ({bus.state, bus.illegal, bus.mem_timeout} !== {e.st, e.ill, e.to}) begin
                        bad++;
                        $display("FAIL %s: state/illegal/mem_timeout got %0d/%0b/%0b want %0d/%0b/%0b",
                                 e.tag, bus.state, bus.illegal, bus.mem_timeout, e.st, e.ill, e.to);
                    end
                    total++;
                    if (bus.ctl !== e.v) begin
                        bad++;
                        $display("FAIL %s: ctl got %h want %h (state %0d)", e.tag, bus.ctl, e.v, e.st);
                    end
                end
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        bus.Inst = 32'h0;
        bus.zero = 1'b0;
        bus.overflow = 1'b0;
        bus.MIO_ready = 1'b1;
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        cyc("rst", S_IF, '0);
        cyc("rst", S_IF, '0);
        reset = 1'b0;
        run_r("add", 32'h00221820, ALU_ADD, 1'b0, 1'b1);
        run_r("add_ovf", 32'h00221820, ALU_ADD, 1'b1, 1'b0);
        run_r("sub", 32'h00221822, ALU_SUB, 1'b0, 1'b1);
        run_r("and_ovf", 32'h00221824, ALU_AND, 1'b1, 1'b1);
        run_r("or", 32'h00221825, ALU_OR, 1'b0, 1'b1);
        run_r("xor", 32'h00221826, ALU_XOR, 1'b0, 1'b1);
        run_r("nor", 32'h00221827, ALU_NOR, 1'b0, 1'b1);
        run_r("slt", 32'h0022182A, ALU_SLT, 1'b0, 1'b1);
        run_r("srl", 32'h00021042, ALU_SRL, 1'b0, 1'b1);
        bus.Inst = 32'h8C220004;
        cyc("lw", S_IF, C_IF_RDY);
        cyc("lw", S_ID, C_ID);
        cyc("lw", S_MA, C_MA);
        for (int i = 0; i < 3; i++) cyc("lw_wait", S_MRD, C_MRD, 1'b0);
        cyc("lw", S_MRD, C_MRD);
        cyc("lw", S_WBL, C_WBL);
        bus.Inst = 32'hAC220004;
        cyc("sw", S_IF, C_IF_RDY);
        cyc("sw", S_ID, C_ID);
        cyc("sw", S_MA, C_MA);
        cyc("sw", S_MWR, C_MWR);
        run3("beq", 32'h10220003, S_BR, C_BEQ);
        run3("bne", 32'h14220003, S_BR, C_BNE);
        run3("j", 32'h08000010, S_J, C_J);
        run3("jal", 32'h0C000010, S_JAL, C_JAL);
        run3("jr", 32'h03E00008, S_JR, C_JR);
        run3("lui", 32'h3C011234, S_LUI, C_LUI);
        run_i("addi_ovf", 32'h20220005, ALU_ADD, 1'b1, 1'b0);
        run_i("addi", 32'h20220005, ALU_ADD, 1'b0, 1'b1);
        run_i("ori_ovf", 32'h34220005, ALU_OR, 1'b1, 1'b1);
        run_i("slti", 32'h28220005, ALU_SLT, 1'b0, 1'b1);
        run_i("andi", 32'h30220005, ALU_AND, 1'b0, 1'b1);
        run_i("xori", 32'h38220005, ALU_XOR, 1'b0, 1'b1);
        run_bad("bad_op", 32'hFC000000);
        run_bad("bad_funct", 32'h00221821);
        bus.Inst = 32'h8C220004;
        cyc("arst", S_IF, C_IF_RDY);
        cyc("arst", S_ID, C_ID);
        cyc("arst", S_MA, C_MA);
        cyc("arst", S_MRD, C_MRD, 1'b0);
        reset = 1'b1;
        cyc("arst", S_IF, '0, 1'b0);
        cyc("arst", S_IF, '0);
        reset = 1'b0;
        bus.Inst = 32'h3C011234;
        for (int i = 0; i < 4; i++) cyc("wdog_wait", S_IF, C_IF_WAIT, 1'b0);
        cyc("wdog_hit", S_IF, C_IF_WAIT, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("wdog_sticky", S_IF, C_IF_RDY, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("wdog_sticky", S_ID, C_ID, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("wdog_sticky", S_LUI, C_LUI, 1'b1, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        cyc("wdog_clr", S_IF, '0);
        mon_on = 1'b0;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/m_ctrl_fsm.md
Name: m_ctrl_fsm

Overview:
- Multi-cycle MIPS control unit that sequences M_datapath: decodes Inst[31:26]/Inst[5:0] and drives every datapath control input once per state.
- Moore FSM with a memory-ready handshake (MIO_ready) and overflow-suppressed write-back.
- Sits beside M_datapath inside the multi-cycle CPU top level; shares clk/reset with it.

Parameters:
- MEM_TIMEOUT, 0, memory-wait watchdog in cycles; 0 disables it.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- Inst  in  32  current IR contents from the datapath.
- zero  in  1  ALU zero flag. Unused: branch qualification is done in the datapath via PCWriteCond/Branch.
- overflow  in  1  ALU signed-overflow flag.
- MIO_ready  in  1  memory/IO access complete.
- PCWrite, PCWriteCond, IorD, IRWrite, ALUSrcA, RegWrite, Branch  out  1 each  datapath controls.
- MemtoReg, RegDst, ALUSrcB, PCSource  out  2 each  datapath mux selects.
- ALU_operation  out  3  AND 000, OR 001, ADD 010, XOR 011, NOR 100, SRL 101, SUB 110, SLT 111.
- MemRead, MemWrite, CPU_MIO  out  1 each  bus request strobes.
- state  out  5  current state code, for debug.
- mem_timeout  out  1  sticky watchdog flag.
- illegal  out  1  illegal-opcode flag (see Optional Feature).

Behaviour:
Mux encodings:
- MemtoReg: 00 ALUOut, 01 MDR, 10 imm<<16, 11 PC.
- RegDst: 00 rt, 01 rd, 10 $31.
- ALUSrcA: 0 PC, 1 A.
- ALUSrcB: 00 B, 01 constant 4, 10 ext-imm, 11 ext-imm<<2.
- PCSource: 00 ALU result, 01 ALUOut, 10 jump target, 11 A.

Outputs and reset:
- All outputs are combinational decode of the state register, except ovf_q and the wait counter, which are registered.
- While reset=1: state=IF, ovf_q=0, counter=0, mem_timeout=0, illegal=0, and every control output is forced to 0.
- Unlisted outputs are 0 in every state.

States:
- IF: MemRead=CPU_MIO=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ADD, PCSource=00. IRWrite and PCWrite are asserted only in the cycle MIO_ready=1, then go to ID. Otherwise hold in IF.
- ID: ALUSrcA=0, ALUSrcB=11, ADD (ALUOut gets branch target). Dispatch on opcode:
  - lw 100011 / sw 101011 -> MA
  - R-type 000000 -> EXR (funct 001000 jr -> JR)
  - beq 000100 / bne 000101 -> BR
  - j 000010 -> J
  - jal 000011 -> JAL
  - addi 001000, slti 001010, andi 001100, ori 001101, xori 001110 -> EXI
  - lui 001111 -> LUI
  - anything else -> illegal path.
- MA: ALUSrcA=1, ALUSrcB=10, ADD -> MRD (lw) or MWR (sw).
- MRD: IorD=1, MemRead=CPU_MIO=1; hold until MIO_ready, then -> WBL.
- MWR: IorD=1, MemWrite=CPU_MIO=1; hold until MIO_ready, then -> IF.
- WBL: RegWrite=1, RegDst=00, MemtoReg=01 -> IF.
- EXR: ALUSrcA=1, ALUSrcB=00, ALU_operation from funct:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 000010 SRL.
  - Any other funct is illegal.
  - Next state -> WBR.
- WBR: RegWrite=~ovf_q, RegDst=01, MemtoReg=00 -> IF.
- EXI: ALUSrcA=1, ALUSrcB=10, op = ADD/SLT/AND/OR/XOR per opcode -> WBI.
- WBI: RegWrite=~ovf_q, RegDst=00, MemtoReg=00 -> IF.
- BR: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01, PCWriteCond=1, Branch=1 for beq and 0 for bne -> IF.
- J: PCWrite=1, PCSource=10 -> IF.
- JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=11 (PC already holds PC+4) -> IF.
- JR: PCWrite=1, PCSource=11 -> IF.
- LUI: RegWrite=1, RegDst=00, MemtoReg=10 -> IF.

Overflow handling:
- ovf_q is captured in EXR/EXI only for ADD/SUB (R-type) and addi; it is 0 for every other operation.

Latency (with MIO_ready=1):
- 3 cycles: beq, bne, j, jal, jr, lui.
- 4 cycles: R-type, I-type ALU, sw.
- 5 cycles: lw.

Memory watchdog:
- When MEM_TIMEOUT>0, the wait counter counts consecutive MIO_ready=0 cycles in IF/MRD/MWR.
- On reaching MEM_TIMEOUT: set mem_timeout, go to IF without IRWrite, PCWrite or RegWrite.
- The counter clears on every state change.

Reset mid-access: async return to IF; pending strobes drop immediately.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: illegal opcode/funct -> HALT state. All controls are 0 there, illegal=1, and HALT is left only by reset.
- Undefined: illegal instruction is a NOP (ID -> IF, no writes) and illegal is tied to 0.

Decomposition:
- Package m_ctrl_pkg: state encoding constants, opcode/funct constants, ALU_operation codes, mux-select encodings.
- One natural sub-module: m_alu_dec, a combinational funct/opcode -> ALU_operation and legality decoder.

Test Plan:
- Reset held 2 cycles, then Inst=0x00221820 (add $3,$1,$2), overflow=0 -> states IF,ID,EXR,WBR; WBR has RegWrite=1, RegDst=01, ALU_operation=010 in EXR.
- Same add with overflow=1 in EXR -> WBR RegWrite=0; next instruction unaffected.
- lw 0x8C220004 with MIO_ready low 3 cycles in MRD -> MRD held 3 extra cycles; WBL MemtoReg=01; 8 cycles total.
- beq 0x10220003 -> BR: PCWriteCond=1, Branch=1, PCSource=01, SUB; bne 0x14220003 gives Branch=0.
- jal 0x0C000010 -> JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=11; 3 cycles.
- Opcode 0x3F, both macro builds: undefined -> back to IF after ID; defined -> illegal=1, HALT, released only by reset. Also check MEM_TIMEOUT=4 with MIO_ready stuck 0 -> mem_timeout=1 after 4 wait cycles.
